data_mem_bank: RTL and testbench
================================

DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width; storage is 2**(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have parameter INIT_ZERO, default 1, which zero-fills all words at time 0 when set.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit, request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit, request accepted this cycle if valid.
REQ-007 The block SHALL have port req_we, input, 1 bit, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits, RISC-V load/store funct3.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits, byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit, response held in the output register.
REQ-012 The block SHALL have port resp_ready, input, 1 bit, consumer takes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits, extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit, access fault.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-016 req_ready SHALL equal (!resp_valid || resp_ready), giving one accepted request per cycle under no backpressure.
REQ-017 The output register SHALL have two states: EMPTY to FULL on accept; FULL to EMPTY on resp_ready without a new accept; FULL stays FULL, with new contents, on resp_ready plus an accept.
REQ-018 Every accepted request, load or store, SHALL produce exactly one response, with resp_valid rising on the edge of acceptance, i.e. 1-cycle latency.
REQ-019 While resp_valid=1 and resp_ready=0, resp_rdata and resp_err SHALL hold stable.
REQ-020 Word index SHALL be req_addr[ADDR_W-1:2] and byte lane SHALL be req_addr[1:0].
REQ-021 Stores SHALL follow req_funct3: 000 (SB) writes only lane with wdata[7:0]; 001 (SH) writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; 010 (SW) writes all lanes; other lanes are unchanged.
REQ-022 Loads SHALL follow req_funct3: 000 LB sign-extends a byte, 100 LBU zero-extends a byte, 001 LH sign-extends a halfword, 101 LHU zero-extends a halfword, 010 LW returns the word.
REQ-023 A store SHALL update memory on its acceptance edge, so a load accepted on the next edge returns the new data.
REQ-024 A req_funct3 of 011, 110 or 111, or a store with 100 or 101, SHALL write nothing and respond resp_err=1, resp_rdata=0.
REQ-025 Address bits beyond storage do not exist, since the address wraps modulo 2**ADDR_W by construction.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force resp_valid=0, resp_rdata=0, resp_err=0 and the state to EMPTY, making req_ready=1.
REQ-027 Reset SHALL NOT alter memory contents; a response pending at reset SHALL be discarded.
REQ-028 No request SHALL be accepted on an edge where rst_n=0.

Configuration
REQ-029 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL write nothing and respond resp_err=1, resp_rdata=0.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, halfword accesses SHALL force addr[0] to 0, word accesses SHALL force addr[1:0] to 00, and resp_err SHALL flag only REQ-024 cases.

Verification
REQ-031 The bench SHALL cover: SW 0x1234ABCD @0xC8, then LH @0xC8 -> 0xFFFFABCD, then LHU @0xCA -> 0x00001234, resp_err=0.
REQ-032 The bench SHALL cover: SW 0 @0xA8, SB 0xFFFFFF80 @0xA9, then LW @0xA8 -> 0x00008000, LB @0xA9 -> 0xFFFFFF80, LBU @0xA9 -> 0x00000080.
REQ-033 The bench SHALL cover: two back-to-back loads with resp_ready=0 for 3 cycles -> first response held stable, req_ready=0, second load accepted on the cycle resp_ready=1, responses in order.
REQ-034 The bench SHALL cover: SW 0xDEADBEEF @0x9C, then LW @0x9D -> resp_err=1 and rdata 0 with the macro; 0xDEADBEEF and err=0 without the macro.
REQ-035 The bench SHALL cover: funct3=011 load -> resp_err=1; SH with funct3=101 -> resp_err=1 and memory unchanged.
REQ-036 The bench SHALL cover: rst_n low asynchronously while resp_valid=1 -> resp_valid=0 and req_ready=1 before the next edge; after release, LW returns the pre-reset stored value.

Source files
------------

// File: rtl/data_mem_bank.sv
// Byte-addressable 32-bit data memory with RISC-V load/store sizing and a single response register.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of being force-aligned.
module data_mem_bank #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;

  // Storage has no reset path; optional power-up zero fill only.
  logic [31:0] mem [WORDS] = '{default: (INIT_ZERO ? 32'h0 : {32{1'bx}})};

  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        raw_lane;
  logic [1:0]        lane;
  logic [2:0]        f3;
  logic              is_half;
  logic              is_word;
  logic              bad_f3;
  logic              misalign;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;

  assign resp_valid = (state == FULL);
  assign req_ready  = (state == EMPTY) || resp_ready;
  assign accept     = req_valid && req_ready;
  assign word_idx   = req_addr[ADDR_W-1:2];
  assign raw_lane   = req_addr[1:0];
  assign f3         = req_funct3;

  always_comb begin
    is_half = (f3[1:0] == 2'b01);
    is_word = (f3[1:0] == 2'b10);
    bad_f3  = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (req_we && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (is_half && raw_lane[0]) || (is_word && (raw_lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err = bad_f3 || misalign;
    // Without the trap, sub-lane address bits are simply ignored for wider accesses.
    if (is_word) begin
      lane = 2'b00;
    end else if (is_half) begin
      lane = {raw_lane[1], 1'b0};
    end else begin
      lane = raw_lane;
    end
  end

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (f3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
    if (acc_err || !req_we) begin
      be = 4'b0000;
    end
  end

  always_comb begin
    rd_word = mem[word_idx];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'h0, rd_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
    if (req_we || acc_err) begin
      ld_data = 32'h0;
    end
  end

  // Write lands on the accept edge so a load on the following edge sees it.
  always_ff @(posedge clk) begin
    if (accept && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][b*8 +: 8] <= wd[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      resp_rdata <= ld_data;
      resp_err   <= acc_err;
    end else if (state == FULL && resp_ready) begin
      state      <= EMPTY;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank: vector table of single requests plus backpressure and reset sequences.
module tb_data_mem_bank;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_mem_bank #(.ADDR_W(8), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one request with resp_ready high and checks the response one edge later.
  task automatic issue(input vec_t v);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    chk({v.name, ".ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.name, ".valid"}, {31'h0, resp_valid}, 32'h1);
    chk({v.name, ".rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, ".err"},   {31'h0, resp_err}, {31'h0, v.exp_err});
  endtask

  initial begin
    vec_t v;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;

    vt.push_back('{"init_lw",   1'b0, 3'b010, 8'h10, 32'h0,        32'h00000000, 1'b0});
    vt.push_back('{"sw_c8",     1'b1, 3'b010, 8'hC8, 32'h1234ABCD, 32'h00000000, 1'b0});
    vt.push_back('{"lh_c8",     1'b0, 3'b001, 8'hC8, 32'h0,        32'hFFFFABCD, 1'b0});
    vt.push_back('{"lhu_ca",    1'b0, 3'b101, 8'hCA, 32'h0,        32'h00001234, 1'b0});
    vt.push_back('{"sw_a8",     1'b1, 3'b010, 8'hA8, 32'h0,        32'h00000000, 1'b0});
    vt.push_back('{"sb_a9",     1'b1, 3'b000, 8'hA9, 32'hFFFFFF80, 32'h00000000, 1'b0});
    vt.push_back('{"lw_a8",     1'b0, 3'b010, 8'hA8, 32'h0,        32'h00008000, 1'b0});
    vt.push_back('{"lb_a9",     1'b0, 3'b000, 8'hA9, 32'h0,        32'hFFFFFF80, 1'b0});
    vt.push_back('{"lbu_a9",    1'b0, 3'b100, 8'hA9, 32'h0,        32'h00000080, 1'b0});
    vt.push_back('{"sw_9c",     1'b1, 3'b010, 8'h9C, 32'hDEADBEEF, 32'h00000000, 1'b0});
`ifdef DMEM_MISALIGN_TRAP_EN
    vt.push_back('{"lw_9d",     1'b0, 3'b010, 8'h9D, 32'h0,        32'h00000000, 1'b1});
`else
    vt.push_back('{"lw_9d",     1'b0, 3'b010, 8'h9D, 32'h0,        32'hDEADBEEF, 1'b0});
`endif
    vt.push_back('{"ld_f3_011", 1'b0, 3'b011, 8'hC8, 32'h0,        32'h00000000, 1'b1});
    vt.push_back('{"sh_f3_101", 1'b1, 3'b101, 8'hC8, 32'h00005555, 32'h00000000, 1'b1});
    vt.push_back('{"lw_c8_chk", 1'b0, 3'b010, 8'hC8, 32'h0,        32'h1234ABCD, 1'b0});
    vt.push_back('{"sw_40",     1'b1, 3'b010, 8'h40, 32'h0,        32'h00000000, 1'b0});
    vt.push_back('{"sh_42",     1'b1, 3'b001, 8'h42, 32'hFFFF89AB, 32'h00000000, 1'b0});
    vt.push_back('{"lw_40",     1'b0, 3'b010, 8'h40, 32'h0,        32'h89AB0000, 1'b0});
    vt.push_back('{"lh_42",     1'b0, 3'b001, 8'h42, 32'h0,        32'hFFFF89AB, 1'b0});
    vt.push_back('{"lb_43",     1'b0, 3'b000, 8'h43, 32'h0,        32'hFFFFFF89, 1'b0});
    vt.push_back('{"sb_f3_100", 1'b1, 3'b100, 8'h40, 32'h000000FF, 32'h00000000, 1'b1});
    vt.push_back('{"lw_40_chk", 1'b0, 3'b010, 8'h40, 32'h0,        32'h89AB0000, 1'b0});
    vt.push_back('{"sw_20",     1'b1, 3'b010, 8'h20, 32'hCAFEF00D, 32'h00000000, 1'b0});

    #1;
    chk("rst.valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err",   {31'h0, resp_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i]);
    end
    @(posedge clk); #1;
    chk("drain.valid", {31'h0, resp_valid}, 32'h0);

    // Backpressure: first response held for 3 cycles while a second load waits.
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'hC8;
    @(posedge clk); #1;
    req_addr = 8'hA8;
    chk("bp.valid0", {31'h0, resp_valid}, 32'h1);
    chk("bp.first0", resp_rdata, 32'h1234ABCD);
    for (int c = 0; c < 3; c++) begin
      chk("bp.ready_low", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      chk("bp.hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp.hold_rdata", resp_rdata, 32'h1234ABCD);
      chk("bp.hold_err",   {31'h0, resp_err}, 32'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.ready_high", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp.second_valid", {31'h0, resp_valid}, 32'h1);
    chk("bp.second_rdata", resp_rdata, 32'h00008000);
    @(posedge clk); #1;
    chk("bp.empty", {31'h0, resp_valid}, 32'h0);

    // Asynchronous reset while a response is pending, then memory survives.
    resp_ready = 1'b0;
    req_valid  = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ar.pending", {31'h0, resp_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", {31'h0, resp_valid}, 32'h0);
    chk("ar.ready", {31'h0, req_ready}, 32'h1);
    chk("ar.rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar.no_resp", {31'h0, resp_valid}, 32'h0);
    v = '{"ar.lw_20", 1'b0, 3'b010, 8'h20, 32'h0, 32'hCAFEF00D, 1'b0};
    issue(v);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
